// File: rtl/data_mem_port.sv
// Byte-addressed load/store front end for one RAM256x32; loads respond 2 cycles after accept, stores 1 (split accesses +1 with MISALIGNED_EN).
// Requests accepted only in IDLE via req_ready; responses are single-cycle pulses and never back-pressured.
module data_mem_port #(
   parameter int ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [31:0]       rsp_rdata,
   output logic              RAM_RE,
   output logic [ADDR_W-1:0] RAM_RADDR,
   output logic              RAM_WE,
   output logic [ADDR_W-1:0] RAM_WADDR,
   output logic [31:0]       RAM_MASK,
   output logic [31:0]       RAM_WDATA,
   input  logic [31:0]       RAM_RDATA
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_LO = 3'd1,
      RD_HI = 3'd2,
      WR_HI = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t            r_state, w_next;
   logic [ADDR_W-1:0] w_req_word;
   logic [1:0]        w_off, r_off, r_size;
   logic              r_uns, w_mis, w_err, w_acc, w_rsp_set;
   logic              r_rsp_vld, r_rsp_err;
   logic [31:0]       r_rsp_rdata, w_rd_al, w_wd_lo, w_bm_lo;
   logic              w_unused_addr;

   function automatic logic [3:0] f_szmask(input logic [1:0] sz);
      case (sz)
         2'b00:   f_szmask = 4'b0001;
         2'b01:   f_szmask = 4'b0011;
         default: f_szmask = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] sz, input logic uns);
      case (sz)
         2'b00:   f_extend = {{24{~uns & d[7]}}, d[7:0]};
         2'b01:   f_extend = {{16{~uns & d[15]}}, d[15:0]};
         default: f_extend = d;
      endcase
   endfunction

   assign w_req_word    = req_addr[ADDR_W+1:2];
   assign w_off         = req_addr[1:0];
   assign w_unused_addr = ^req_addr[31:ADDR_W+2];
   assign w_mis = (req_size == 2'b01 && w_off == 2'd3) || (req_size == 2'b10 && w_off != 2'd0);
   assign w_acc = req_valid && req_ready;

`ifdef MISALIGNED_EN
   logic [ADDR_W-1:0] r_word, w_word_nx;
   logic [31:0]       r_wdata, r_lo, w_wdat, w_wd_hi, w_bm_hi;
   logic              r_mis;
   logic [1:0]        w_wsz, w_woff;
   logic [7:0]        w_lanes8;
   logic [63:0]       w_wd64, w_bm64, w_rd64;

   assign w_err     = (req_size == 2'b11);
   assign w_word_nx = r_word + {{(ADDR_W-1){1'b0}}, 1'b1};

   // In IDLE the lanes come straight from the request; in WR_HI from the latched copy.
   assign w_wsz    = (r_state == IDLE) ? req_size  : r_size;
   assign w_woff   = (r_state == IDLE) ? w_off     : r_off;
   assign w_wdat   = (r_state == IDLE) ? req_wdata : r_wdata;
   assign w_lanes8 = {4'b0000, f_szmask(w_wsz)} << w_woff;
   assign w_wd64   = {32'b0, w_wdat} << {w_woff, 3'b000};
   always_comb begin
      w_bm64 = '0;
      for (int i = 0; i < 8; i++) w_bm64[8*i +: 8] = {8{w_lanes8[i]}};
   end
   assign w_wd_lo = w_wd64[31:0];
   assign w_wd_hi = w_wd64[63:32];
   assign w_bm_lo = w_bm64[31:0];
   assign w_bm_hi = w_bm64[63:32];

   assign w_rd64  = (r_state == RD_HI) ? {RAM_RDATA, r_lo} : {32'b0, RAM_RDATA};
   assign w_rd_al = 32'(w_rd64 >> {r_off, 3'b000});

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_word  <= '0;
         r_wdata <= '0;
         r_mis   <= 1'b0;
         r_lo    <= '0;
      end else begin
         if (w_acc) begin
            r_word  <= w_req_word;
            r_wdata <= req_wdata;
            r_mis   <= w_mis;
         end
         if (r_state == RD_LO) r_lo <= RAM_RDATA;
      end
   end
`else
   logic [3:0] w_lanes4;

   assign w_err    = (req_size == 2'b11) || w_mis;
   assign w_lanes4 = f_szmask(req_size) << w_off;
   assign w_wd_lo  = req_wdata << {w_off, 3'b000};
   always_comb begin
      w_bm_lo = '0;
      for (int i = 0; i < 4; i++) w_bm_lo[8*i +: 8] = {8{w_lanes4[i]}};
   end
   assign w_rd_al = RAM_RDATA >> {r_off, 3'b000};
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_acc) begin
            if (w_err)       w_next = RESP;
`ifdef MISALIGNED_EN
            else if (req_we) w_next = w_mis ? WR_HI : RESP;
`else
            else if (req_we) w_next = RESP;
`endif
            else             w_next = RD_LO;
         end
`ifdef MISALIGNED_EN
         RD_LO:   w_next = r_mis ? RD_HI : IDLE;
         RD_HI:   w_next = IDLE;
         WR_HI:   w_next = RESP;
`else
         RD_LO:   w_next = IDLE;
`endif
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (r_state == IDLE) && !RST;
      RAM_RE    = 1'b0;
      RAM_WE    = 1'b0;
      RAM_RADDR = w_req_word;
      RAM_WADDR = w_req_word;
      RAM_MASK  = '1;
      RAM_WDATA = w_wd_lo;
      w_rsp_set = ((r_state != RESP) && (w_next == RESP)) ||
                  ((r_state == RD_LO || r_state == RD_HI) && (w_next == IDLE));
      case (r_state)
         IDLE: begin
            RAM_RE = w_acc && !req_we && !w_err;
            RAM_WE = w_acc && req_we && !w_err;
            if (w_acc && req_we && !w_err) RAM_MASK = ~w_bm_lo;
         end
`ifdef MISALIGNED_EN
         RD_LO: begin
            RAM_RE    = r_mis;
            RAM_RADDR = w_word_nx;
         end
         WR_HI: begin
            RAM_WE    = 1'b1;
            RAM_WADDR = w_word_nx;
            RAM_MASK  = ~w_bm_hi;
            RAM_WDATA = w_wd_hi;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_off       <= '0;
         r_size      <= '0;
         r_uns       <= 1'b0;
         r_rsp_vld   <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         if (w_acc) begin
            r_off  <= w_off;
            r_size <= req_size;
            r_uns  <= req_unsigned;
         end
         r_rsp_vld <= w_rsp_set;
         r_rsp_err <= (r_state == IDLE) && w_acc && w_err;
         if ((r_state == IDLE) && w_acc && w_err)
            r_rsp_rdata <= '0;
         else if ((r_state == RD_LO || r_state == RD_HI) && (w_next == IDLE))
            r_rsp_rdata <= f_extend(w_rd_al, r_size, r_uns);
      end
   end

   assign rsp_valid = r_rsp_vld;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;

endmodule
